// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and default frame geometry.
package uart_pkg;

    localparam int unsigned UART_DATA_BITS   = 8;
    localparam int unsigned UART_SAMPLE_RATE = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_rx_state_t;

endpackage : uart_pkg

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for an asynchronous single-bit input, with selectable reset value.
module uart_sync2 #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic i_clock,
    input  logic i_reset,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    // Two-stage capture of the asynchronous input.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_meta <= RESET_VAL;
            r_sync <= RESET_VAL;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule : uart_sync2

// File: rtl/uart_rx_oversampled.sv
// UART receiver: oversampled start validation, mid-bit data sampling, stop check.
module uart_rx_oversampled
    import uart_pkg::*;
#(
    parameter int unsigned DATA_BITS   = UART_DATA_BITS,
    parameter int unsigned SAMPLE_RATE = UART_SAMPLE_RATE
) (
    input  logic                 i_clock,
    input  logic                 i_reset,
    input  logic                 i_sample_tick,
    input  logic                 i_rx,
    output logic [DATA_BITS-1:0] o_rx_data,
    output logic                 o_rx_valid,
    output logic                 o_framing_error,
    output logic                 o_busy
);

    localparam int unsigned TICK_W = $clog2(SAMPLE_RATE);
    localparam int unsigned BIT_W  = $clog2(DATA_BITS + 1);

    localparam logic [TICK_W-1:0] TICK_MID = TICK_W'(SAMPLE_RATE / 2 - 1);
    localparam logic [TICK_W-1:0] TICK_END = TICK_W'(SAMPLE_RATE - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST = BIT_W'(DATA_BITS - 1);

    uart_rx_state_t r_state;
    uart_rx_state_t w_state_next;

    logic                 w_rxs;
    logic                 r_rxs_d;
    logic                 w_fall;
    logic [TICK_W-1:0]    r_tick_cnt;
    logic [BIT_W-1:0]     r_bit_cnt;
    logic [DATA_BITS-1:0] r_shift;
    logic [DATA_BITS-1:0] r_rx_data;
    logic                 r_rx_valid;
    logic                 r_framing_error;
    logic                 r_busy;

    logic w_tick_clr;
    logic w_tick_inc;
    logic w_bit_clr;
    logic w_shift;
    logic w_load;
    logic w_ferr;

    uart_sync2 #(
        .RESET_VAL (1'b1)
    ) u_sync_rx (
        .i_clock (i_clock),
        .i_reset (i_reset),
        .i_d     (i_rx),
        .o_q     (w_rxs)
    );

    // Delayed copy of the synchronized line for falling-edge detection.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_rxs_d <= 1'b1;
        end else begin
            r_rxs_d <= w_rxs;
        end
    end

    assign w_fall = r_rxs_d & ~w_rxs;

    // FSM state register.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and datapath control; sampling decisions happen only on ticks.
    always_comb begin
        w_state_next = r_state;
        w_tick_clr   = 1'b0;
        w_tick_inc   = 1'b0;
        w_bit_clr    = 1'b0;
        w_shift      = 1'b0;
        w_load       = 1'b0;
        w_ferr       = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_fall) begin
                    w_state_next = START;
                    w_tick_clr   = 1'b1;
                end
            end
            START: begin
                if (i_sample_tick) begin
                    if (r_tick_cnt == TICK_MID) begin
                        if (!w_rxs) begin
                            w_state_next = DATA;
                            w_tick_clr   = 1'b1;
                            w_bit_clr    = 1'b1;
                        end else begin
                            w_state_next = IDLE;
                        end
                    end else begin
                        w_tick_inc = 1'b1;
                    end
                end
            end
            DATA: begin
                if (i_sample_tick) begin
                    if (r_tick_cnt == TICK_END) begin
                        w_shift    = 1'b1;
                        w_tick_clr = 1'b1;
                        if (r_bit_cnt == BIT_LAST) begin
                            w_state_next = STOP;
                        end
                    end else begin
                        w_tick_inc = 1'b1;
                    end
                end
            end
            STOP: begin
                if (i_sample_tick) begin
                    if (r_tick_cnt == TICK_END) begin
                        w_state_next = IDLE;
                        if (w_rxs) begin
                            w_load = 1'b1;
                        end else begin
                            w_ferr = 1'b1;
                        end
                    end else begin
                        w_tick_inc = 1'b1;
                    end
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // Tick/bit counters and LSB-first shift register.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_tick_cnt <= '0;
            r_bit_cnt  <= '0;
            r_shift    <= '0;
        end else begin
            if (w_tick_clr) begin
                r_tick_cnt <= '0;
            end else if (w_tick_inc) begin
                r_tick_cnt <= r_tick_cnt + TICK_W'(1);
            end
            if (w_bit_clr) begin
                r_bit_cnt <= '0;
            end else if (w_shift) begin
                r_bit_cnt <= r_bit_cnt + BIT_W'(1);
            end
            if (w_shift) begin
                r_shift <= {w_rxs, r_shift[DATA_BITS-1:1]};
            end
        end
    end

    // Registered outputs; the word is only replaced by a correctly framed one.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_rx_data       <= '0;
            r_rx_valid      <= 1'b0;
            r_framing_error <= 1'b0;
            r_busy          <= 1'b0;
        end else begin
            r_rx_valid      <= w_load;
            r_framing_error <= w_ferr;
            r_busy          <= (w_state_next != IDLE);
            if (w_load) begin
                r_rx_data <= r_shift;
            end
        end
    end

    assign o_rx_data       = r_rx_data;
    assign o_rx_valid      = r_rx_valid;
    assign o_framing_error = r_framing_error;
    assign o_busy          = r_busy;

endmodule : uart_rx_oversampled

// File: tb/tb_uart_rx_oversampled.sv
// Self-checking bench for uart_rx_oversampled (8-bit and 7-bit instances).
module tb_uart_rx_oversampled;

    localparam int SR   = 16;
    localparam int TD   = 10;          // clocks per sample tick, shortened for run time
    localparam int BITC = SR * TD;     // clocks per bit period
    localparam int HALF = SR / 2;

    logic clk = 1'b0;
    logic rst;
    logic tick;
    logic rx8, rx7;

    logic [7:0] data8;
    logic       valid8, ferr8, busy8;
    logic [6:0] data7;
    logic       valid7, ferr7, busy7;

    uart_rx_oversampled #(.DATA_BITS(8), .SAMPLE_RATE(SR)) dut8 (
        .i_clock(clk), .i_reset(rst), .i_sample_tick(tick), .i_rx(rx8),
        .o_rx_data(data8), .o_rx_valid(valid8), .o_framing_error(ferr8), .o_busy(busy8)
    );

    uart_rx_oversampled #(.DATA_BITS(7), .SAMPLE_RATE(SR)) dut7 (
        .i_clock(clk), .i_reset(rst), .i_sample_tick(tick), .i_rx(rx7),
        .o_rx_data(data7), .o_rx_valid(valid7), .o_framing_error(ferr7), .o_busy(busy7)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Baud-generator stand-in: one-clock tick every TD clocks.
    initial begin
        tick = 1'b0;
        forever begin
            repeat (TD - 1) @(negedge clk);
            tick = 1'b1;
            @(negedge clk);
            tick = 1'b0;
        end
    end

    // Event recorder.
    logic [7:0] vq8[$];
    int         vt8[$];
    logic       vb8[$];
    logic [6:0] vq7[$];
    int         vt7[$];
    int fe8 = 0, fe7 = 0, both = 0, bc8 = 0;

    always @(negedge clk) begin
        if (valid8) begin vq8.push_back(data8); vt8.push_back(cyc); vb8.push_back(busy8); end
        if (valid7) begin vq7.push_back(data7); vt7.push_back(cyc); end
        if (ferr8) fe8 <= fe8 + 1;
        if (ferr7) fe7 <= fe7 + 1;
        if (busy8) bc8 <= bc8 + 1;
        if ((valid8 && ferr8) || (valid7 && ferr7)) both <= both + 1;
    end

    int n_vec = 0;
    int n_err = 0;
    logic [7:0] exp8 = 8'h00;
    logic [6:0] exp7 = 7'h00;

    // Reference timing: stop sample tick index from START entry, 3-clock edge latency.
    function automatic int lat_hi(input int db);
        return (HALF + (db + 1) * SR) * TD + 3;
    endfunction

    function automatic int lat_lo(input int db);
        return lat_hi(db) - TD + 1;
    endfunction

    task automatic hold(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_line(input bit l7, input logic v);
        if (l7) rx7 = v; else rx8 = v;
    endtask

    // Serial frame: start, nb data bits LSB first, one stop bit of value stop_v.
    task automatic send_frame(input bit l7, input logic [8:0] d, input int nb,
                              input logic stop_v, output int t0);
        t0 = cyc;
        set_line(l7, 1'b0);
        hold(BITC);
        for (int i = 0; i < nb; i++) begin
            set_line(l7, d[i]);
            hold(BITC);
        end
        set_line(l7, stop_v);
        hold(BITC);
    endtask

    task automatic test_reset();
        rst = 1'b1; rx8 = 1'b1; rx7 = 1'b1;
        hold(5);
        n_vec++;
        if ({data8, valid8, ferr8, busy8} !== 11'h0) begin
            n_err++; $display("FAIL reset8: got %h required 0", {data8, valid8, ferr8, busy8});
        end
        n_vec++;
        if ({data7, valid7, ferr7, busy7} !== 10'h0) begin
            n_err++; $display("FAIL reset7: got %h required 0", {data7, valid7, ferr7, busy7});
        end
        rst = 1'b0;
        hold(20);
    endtask

    task automatic test_single();
        int t0, fe0, bc0, lat;
        fe0 = fe8; bc0 = bc8;
        send_frame(1'b0, 9'h055, 8, 1'b1, t0);
        hold(BITC);
        exp8 = 8'h55;
        n_vec++;
        if (vq8.size() != 1) begin
            n_err++; $display("FAIL single_count: got %0d valid pulses required 1", vq8.size());
        end else begin
            lat = vt8[0] - t0;
            n_vec++;
            if (vq8[0] !== 8'h55) begin n_err++; $display("FAIL single_data: got %h required 55", vq8[0]); end
            n_vec++;
            if (lat < lat_lo(8) || lat > lat_hi(8)) begin
                n_err++; $display("FAIL single_latency: got %0d required %0d..%0d", lat, lat_lo(8), lat_hi(8));
            end
            n_vec++;
            if (vb8[0] !== 1'b0) begin n_err++; $display("FAIL single_busy_fall: got %b required 0", vb8[0]); end
            n_vec++;
            if (bc8 - bc0 != vt8[0] - t0 - 3) begin
                n_err++; $display("FAIL single_busy_span: got %0d required %0d", bc8 - bc0, vt8[0] - t0 - 3);
            end
        end
        n_vec++;
        if (data8 !== exp8) begin n_err++; $display("FAIL single_hold: got %h required %h", data8, exp8); end
        n_vec++;
        if (fe8 != fe0) begin n_err++; $display("FAIL single_ferr: got %0d pulses required 0", fe8 - fe0); end
        vq8.delete(); vt8.delete(); vb8.delete();
    endtask

    task automatic test_back_to_back();
        int t0, t1;
        send_frame(1'b0, 9'h0A3, 8, 1'b1, t0);
        send_frame(1'b0, 9'h00F, 8, 1'b1, t1);
        hold(BITC);
        exp8 = 8'h0F;
        n_vec++;
        if (vq8.size() != 2) begin
            n_err++; $display("FAIL b2b_count: got %0d required 2", vq8.size());
        end else begin
            n_vec++;
            if (vq8[0] !== 8'hA3 || vq8[1] !== 8'h0F) begin
                n_err++; $display("FAIL b2b_data: got %h %h required a3 0f", vq8[0], vq8[1]);
            end
        end
        n_vec++;
        if (data8 !== exp8) begin n_err++; $display("FAIL b2b_hold: got %h required %h", data8, exp8); end
        vq8.delete(); vt8.delete(); vb8.delete();
    endtask

    task automatic test_glitch();
        int fe0;
        fe0 = fe8;
        rx8 = 1'b0;
        hold(4 * TD);
        rx8 = 1'b1;
        hold(2 * TD);
        n_vec++;
        if (busy8 !== 1'b1) begin n_err++; $display("FAIL glitch_busy_mid: got %b required 1", busy8); end
        hold(4 * TD);
        n_vec++;
        if (busy8 !== 1'b0) begin n_err++; $display("FAIL glitch_idle: got %b required 0", busy8); end
        hold(2 * BITC);
        n_vec++;
        if (vq8.size() != 0 || fe8 != fe0) begin
            n_err++; $display("FAIL glitch_outputs: got %0d valid %0d ferr required 0 0", vq8.size(), fe8 - fe0);
        end
        vq8.delete(); vt8.delete(); vb8.delete();
    endtask

    task automatic test_framing();
        int t0, fe0;
        fe0 = fe8;
        send_frame(1'b0, 9'h0FF, 8, 1'b0, t0);
        hold(BITC + BITC / 2);
        n_vec++;
        if (busy8 !== 1'b0) begin n_err++; $display("FAIL break_busy: got %b required 0", busy8); end
        hold(BITC + BITC / 2);
        rx8 = 1'b1;
        hold(2 * BITC);
        n_vec++;
        if (fe8 - fe0 != 1) begin n_err++; $display("FAIL ferr_count: got %0d required 1", fe8 - fe0); end
        n_vec++;
        if (vq8.size() != 0) begin n_err++; $display("FAIL ferr_valid: got %0d required 0", vq8.size()); end
        n_vec++;
        if (data8 !== exp8) begin n_err++; $display("FAIL ferr_hold: got %h required %h", data8, exp8); end
        n_vec++;
        if (busy8 !== 1'b0) begin n_err++; $display("FAIL ferr_restart: got %b required 0", busy8); end
        vq8.delete(); vt8.delete(); vb8.delete();
    endtask

    task automatic test_reset_mid();
        int t0, fe0;
        logic [7:0] d;
        d = 8'h3C;
        rx8 = 1'b0;
        hold(BITC);
        for (int i = 0; i < 4; i++) begin rx8 = d[i]; hold(BITC); end
        rx8 = d[4];
        hold(BITC / 2);
        rst = 1'b1;
        hold(2);
        n_vec++;
        if ({data8, valid8, ferr8, busy8} !== 11'h0) begin
            n_err++; $display("FAIL midreset_outputs: got %h required 0", {data8, valid8, ferr8, busy8});
        end
        rx8 = 1'b1;
        hold(BITC);
        rst = 1'b0;
        exp8 = 8'h00; exp7 = 7'h00;
        fe0 = fe8;
        hold(2 * BITC);
        n_vec++;
        if (vq8.size() != 0 || fe8 != fe0 || busy8 !== 1'b0) begin
            n_err++; $display("FAIL midreset_abort: got %0d valid %0d ferr busy %b required 0 0 0",
                              vq8.size(), fe8 - fe0, busy8);
        end
        send_frame(1'b0, 9'h0C3, 8, 1'b1, t0);
        hold(BITC);
        exp8 = 8'hC3;
        n_vec++;
        if (vq8.size() != 1 || data8 !== exp8) begin
            n_err++; $display("FAIL midreset_next: got %0d pulses data %h required 1 %h", vq8.size(), data8, exp8);
        end
        vq8.delete(); vt8.delete(); vb8.delete();
    endtask

    task automatic test_7bit();
        int t0, lat;
        send_frame(1'b1, 9'h041, 7, 1'b1, t0);
        hold(BITC);
        exp7 = 7'h41;
        n_vec++;
        if (vq7.size() != 1) begin
            n_err++; $display("FAIL b7_count: got %0d required 1", vq7.size());
        end else begin
            lat = vt7[0] - t0;
            n_vec++;
            if (vq7[0] !== 7'h41) begin n_err++; $display("FAIL b7_data: got %h required 41", vq7[0]); end
            n_vec++;
            if (lat < lat_lo(7) || lat > lat_hi(7)) begin
                n_err++; $display("FAIL b7_latency: got %0d required %0d..%0d", lat, lat_lo(7), lat_hi(7));
            end
        end
        n_vec++;
        if (data7 !== exp7 || vq8.size() != 0) begin
            n_err++; $display("FAIL b7_hold: got %h (8-bit pulses %0d) required %h (0)", data7, vq8.size(), exp7);
        end
        vq7.delete(); vt7.delete();
    endtask

    task automatic test_random();
        int t0, fe0, bc0, lat, nb;
        bit l7;
        logic [8:0] d;
        logic stop_v;
        for (int k = 0; k < 16; k++) begin
            l7     = ($urandom_range(0, 3) == 0);
            nb     = l7 ? 7 : 8;
            d      = 9'($urandom);
            stop_v = ($urandom_range(0, 4) != 0);
            fe0    = l7 ? fe7 : fe8;
            bc0    = bc8;
            send_frame(l7, d, nb, stop_v, t0);
            hold(2);
            if (!l7) begin
                if (stop_v) exp8 = d[7:0];
                n_vec++;
                if (vq8.size() != (stop_v ? 1 : 0) || fe8 - fe0 != (stop_v ? 0 : 1) || data8 !== exp8) begin
                    n_err++; $display("FAIL rand8[%0d]: got %0d valid %0d ferr data %h required stop=%b data %h",
                                      k, vq8.size(), fe8 - fe0, data8, stop_v, exp8);
                end else if (stop_v) begin
                    lat = vt8[0] - t0;
                    n_vec++;
                    if (lat < lat_lo(8) || lat > lat_hi(8) || bc8 - bc0 != lat - 3) begin
                        n_err++; $display("FAIL rand8_timing[%0d]: got lat %0d busy %0d required %0d..%0d busy lat-3",
                                          k, lat, bc8 - bc0, lat_lo(8), lat_hi(8));
                    end
                end
            end else begin
                if (stop_v) exp7 = d[6:0];
                n_vec++;
                if (vq7.size() != (stop_v ? 1 : 0) || fe7 - fe0 != (stop_v ? 0 : 1) || data7 !== exp7) begin
                    n_err++; $display("FAIL rand7[%0d]: got %0d valid %0d ferr data %h required stop=%b data %h",
                                      k, vq7.size(), fe7 - fe0, data7, stop_v, exp7);
                end else if (stop_v) begin
                    lat = vt7[0] - t0;
                    n_vec++;
                    if (lat < lat_lo(7) || lat > lat_hi(7)) begin
                        n_err++; $display("FAIL rand7_timing[%0d]: got %0d required %0d..%0d",
                                          k, lat, lat_lo(7), lat_hi(7));
                    end
                end
            end
            vq8.delete(); vt8.delete(); vb8.delete(); vq7.delete(); vt7.delete();
            set_line(l7, 1'b1);
            hold((stop_v ? 0 : 4) + $urandom_range(0, BITC / 2));
        end
    endtask

    task automatic test_no_overlap();
        n_vec++;
        if (both != 0) begin n_err++; $display("FAIL overlap: got %0d cycles required 0", both); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_glitch();
        test_framing();
        test_reset_mid();
        test_7bit();
        test_random();
        test_no_overlap();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_uart_rx_oversampled

// File: doc/uart_rx_oversampled.md
# uart_rx_oversampled

UART receiver that recovers 8N1-style serial frames from the line using the 16x oversampling tick produced by the baud rate generator. It synchronizes the asynchronous `Rx` pin, detects and validates the start bit, samples each data bit at its midpoint, checks the stop bit and presents the received word with a one-cycle valid strobe. It sits between the pad and the UART receive-side consumer (FIFO or register interface).

## Interface
- `DATA_BITS`, 8, data bits per frame, LSB first (legal 5..9).
- `SAMPLE_RATE`, 16, ticks per bit period; must be even and at least 4.
- `Clock`  input  1  system clock; all state updates on the rising edge.
- `Reset`  input  1  asynchronous, active-high reset.
- `SampleTick`  input  1  one-`Clock`-wide pulse at `SAMPLE_RATE` x baud, from the baud rate generator.
- `Rx`  input  1  asynchronous serial line, idle high.
- `RxData`  output  `DATA_BITS`  last correctly framed word; held until the next valid frame.
- `RxValid`  output  1  one-`Clock` pulse; `RxData` is new on this cycle.
- `FramingError`  output  1  one-`Clock` pulse; stop bit sampled low.
- `Busy`  output  1  high while state is not IDLE.

## Operation
- `Rx` passes through a 2-flop synchronizer (reset value 1) to give `RxS`. Falling-edge detect compares `RxS` with a registered copy.
- Tick counter `TickCnt` has width `$clog2(SAMPLE_RATE)`. Bit counter `BitCnt` has width `$clog2(DATA_BITS+1)`. Both advance only on `SampleTick`.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE -> START on a falling edge of `RxS`. On entry `TickCnt` is cleared. The edge is detected on any `Clock`, not only on tick cycles.
  - START: on a tick with `TickCnt == SAMPLE_RATE/2-1`, the line is sampled at mid start bit.
    - If `RxS == 0`: go to DATA and clear `TickCnt` and `BitCnt`.
    - If `RxS == 1`: treat as a glitch and return to IDLE with no outputs.
  - DATA: on a tick with `TickCnt == SAMPLE_RATE-1`, shift `RxS` into the MSB of the shift register (right shift, so LSB arrives first), clear `TickCnt` and increment `BitCnt`. After bit `DATA_BITS-1` is captured, go to STOP.
  - STOP: on a tick with `TickCnt == SAMPLE_RATE-1`, sample `RxS`.
    - If 1: load `RxData` from the shift register and pulse `RxValid`.
    - If 0: pulse `FramingError` and leave `RxData` unchanged.
    - Go to IDLE in both cases.
- After a framing error, IDLE needs a fresh high-to-low edge. A held-low line (break) therefore never restarts reception.
- There is no buffering. A new frame overwrites `RxData` only when it completes, so the consumer must capture `RxData` on `RxValid`.
- `SampleTick` arriving while in IDLE has no effect.

## Timing
- Reset values: `RxData = 0`, `RxValid = 0`, `FramingError = 0`, `Busy = 0`. State is IDLE, counters are 0, shift register is 0, synchronizer flops are 1.
- Edge-detect latency from `Rx` to START entry is 3 `Clock` cycles (2 sync flops plus the edge register).
- Sample points, in ticks counted from START entry:
  - start bit: tick `SAMPLE_RATE/2`
  - data bit k: tick `SAMPLE_RATE/2 + (k+1)*SAMPLE_RATE`
  - stop bit: tick `SAMPLE_RATE/2 + (DATA_BITS+1)*SAMPLE_RATE`
- `RxValid` and `FramingError` are registered. Each asserts on the `Clock` edge after the stop-sample tick and lasts exactly 1 cycle. The two are never high together.
- `Busy` falls on the same edge that asserts `RxValid` or `FramingError`.
- A frame can begin immediately after STOP. A falling edge on the first IDLE cycle is accepted.
- Reset asserted mid-frame returns all state and outputs to their reset values immediately. No partial word is output.

## Structure
- Shared package `uart_pkg` holds:
  - `uart_rx_state_t` enum (IDLE, START, DATA, STOP);
  - the defaults `UART_DATA_BITS = 8` and `UART_SAMPLE_RATE = 16`, shared with the transmitter and the baud rate generator.
- Sub-module `uart_sync2`: a parameterized-reset-value 2-flop synchronizer, reused for other asynchronous inputs.
- The tick source is external. This block does not instantiate the baud rate generator.

## Test plan
All scenarios use 50 MHz `Clock`, 19200 baud and `SAMPLE_RATE` 16 (tick every 162 cycles), with the baud rate generator driving `SampleTick`.
- Send frame 0x55 with a valid stop bit -> one `RxValid` pulse with `RxData = 0x55`, `FramingError` stays 0, and `Busy` spans the frame.
- Send 0xA3 then 0x0F back-to-back with no idle gap -> two `RxValid` pulses with `RxData` 0xA3 then 0x0F.
- Drive `Rx` low for 4 ticks then high (glitch) -> FSM returns to IDLE at tick 8, with no `RxValid` and no `FramingError`.
- Send 0xFF with the stop bit forced low, then hold the line low for 3 bit periods, then release -> one `FramingError` pulse, `RxData` keeps its previous value, and no new frame starts until a fresh falling edge.
- Assert `Reset` during data bit 4 of 0x3C, release, then send 0xC3 -> all outputs are 0 during reset, there is no output for the aborted frame, and `RxValid` comes with `RxData = 0xC3`.
- `DATA_BITS = 7`: send 0x41 -> `RxValid` with `RxData = 7'h41`, and the stop bit is sampled one bit period earlier than in the 8-bit case.
